// File: rtl/str_div_pipe.sv
// Streaming restoring divider. Operands enter through a valid/ready handshake,
// ride through ceil(DDW/BPS) iteration stages that each resolve BPS quotient
// bits, and leave through one registered result stage that applies signs and
// the divide-by-zero quotient. Every stage stalls independently under
// backpressure, so transfers are never lost, duplicated or reordered.
module str_div_pipe #(
  parameter int DDW    = 16,
  parameter int DSW    = 16,
  parameter int BPS    = 1,
  parameter int SIGNED = 0,
  parameter int UW     = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [DDW-1:0] in_dividend,
  input  logic [DSW-1:0] in_divisor,
  input  logic [UW-1:0]  in_user,
  input  logic           in_last,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [DDW-1:0] out_quotient,
  output logic [DSW-1:0] out_remainder,
  output logic           out_dbz,
  output logic           out_ovf,
  output logic [UW-1:0]  out_user,
  output logic           out_last,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int NS     = (DDW + BPS - 1) / BPS;
  localparam int LAST_N = DDW - (NS - 1) * BPS;

  // n restoring steps on {partial remainder, dividend/quotient shifter}.
  // The compare operand is one bit wider than the divisor so the shifted
  // remainder never wraps; after the step it is back below the divisor.
  function automatic logic [DSW+DDW-1:0] div_steps(input logic [DSW-1:0] rem_in,
                                                   input logic [DDW-1:0] dq_in,
                                                   input logic [DSW-1:0] dsr,
                                                   input int n);
    logic [DSW:0]   r;
    logic [DSW-1:0] rl;
    logic [DDW-1:0] q;
    rl = rem_in;
    q  = dq_in;
    r  = '0;
    for (int i = 0; i < BPS; i++) begin
      if (i < n) begin
        r = {rl, q[DDW-1]};
        q = {q[DDW-2:0], 1'b0};
        if (r >= {1'b0, dsr}) begin
          r    = r - {1'b0, dsr};
          q[0] = 1'b1;
        end
        rl = r[DSW-1:0];
      end
    end
    return {rl, q};
  endfunction

  // Conditional two's-complement negate, dividend/quotient width.
  function automatic logic [DDW-1:0] cneg_q(input logic [DDW-1:0] v, input logic en);
    logic signed [DDW-1:0] s;
    s = signed'(v);
    return en ? unsigned'(-s) : v;
  endfunction

  // Conditional two's-complement negate, divisor/remainder width.
  function automatic logic [DSW-1:0] cneg_r(input logic [DSW-1:0] v, input logic en);
    logic signed [DSW-1:0] s;
    s = signed'(v);
    return en ? unsigned'(-s) : v;
  endfunction

  logic           dvd_neg, dsr_neg, in_dbz, in_ovf;
  logic [DDW-1:0] dvd_mag;
  logic [DSW-1:0] dsr_mag;

  // Operand magnitudes and special-case flags, formed before the first stage.
  always_comb begin
    dvd_neg = (SIGNED != 0) && in_dividend[DDW-1];
    dsr_neg = (SIGNED != 0) && in_divisor[DSW-1];
    dvd_mag = cneg_q(in_dividend, dvd_neg);
    dsr_mag = cneg_r(in_divisor, dsr_neg);
    in_dbz  = (in_divisor == '0);
    in_ovf  = (SIGNED != 0) && (in_dividend == {1'b1, {(DDW-1){1'b0}}}) &&
              (in_divisor == '1);
  end

  logic [NS-1:0]  vld_p, rdy_p, negq_p, negr_p, dbz_p, ovf_p, last_p;
  logic [DSW-1:0] rem_p  [NS];
  logic [DDW-1:0] dq_p   [NS];
  logic [DSW-1:0] dsr_p  [NS];
  logic [UW-1:0]  user_p [NS];
  logic           res_rdy;

  assign res_rdy  = ~out_valid | out_ready;
  assign in_ready = rdy_p[0];

  for (genvar k = 0; k < NS; k++) begin : g_stage
    logic           up_vld, negq_i, negr_i, dbz_i, ovf_i, last_i;
    logic [DSW-1:0] rem_i, dsr_i;
    logic [DDW-1:0] dq_i;
    logic [UW-1:0]  user_i;
    logic [DSW+DDW-1:0] step;

    if (k == 0) begin : g_src_in
      assign up_vld = in_valid;
      assign rem_i  = '0;
      assign dq_i   = dvd_mag;
      assign dsr_i  = dsr_mag;
      assign negq_i = dvd_neg ^ dsr_neg;
      assign negr_i = dvd_neg;
      assign dbz_i  = in_dbz;
      assign ovf_i  = in_ovf;
      assign user_i = in_user;
      assign last_i = in_last;
    end else begin : g_src_prev
      assign up_vld = vld_p[k-1];
      assign rem_i  = rem_p[k-1];
      assign dq_i   = dq_p[k-1];
      assign dsr_i  = dsr_p[k-1];
      assign negq_i = negq_p[k-1];
      assign negr_i = negr_p[k-1];
      assign dbz_i  = dbz_p[k-1];
      assign ovf_i  = ovf_p[k-1];
      assign user_i = user_p[k-1];
      assign last_i = last_p[k-1];
    end

    // A stage can accept whenever any stage from here to the output has a bubble.
    assign rdy_p[k] = res_rdy | ~(&vld_p[NS-1:k]);
    assign step     = div_steps(rem_i, dq_i, dsr_i, (k == NS - 1) ? LAST_N : BPS);

    // Stage valid: follows upstream whenever this stage can move.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_p[k] <= 1'b0;
      else if (rdy_p[k]) vld_p[k] <= up_vld;
    end

    // Stage data: loads on its own handshake only, holds while stalled.
    always_ff @(posedge clk) begin
      if (rdy_p[k] && up_vld) begin
        rem_p[k]  <= step[DSW+DDW-1:DDW];
        dq_p[k]   <= step[DDW-1:0];
        dsr_p[k]  <= dsr_i;
        negq_p[k] <= negq_i;
        negr_p[k] <= negr_i;
        dbz_p[k]  <= dbz_i;
        ovf_p[k]  <= ovf_i;
        user_p[k] <= user_i;
        last_p[k] <= last_i;
      end
    end
  end

  // ---- result stage ----
  // With a zero divisor the iterations subtract nothing, so the remainder
  // register already holds the low DSW dividend bits (magnitude); negating it
  // for a negative dividend restores the raw truncated dividend. Only the
  // quotient needs forcing. The overflow case naturally yields 2^(DDW-1), r=0.
  logic [DDW-1:0] q_fin;
  logic [DSW-1:0] r_fin;

  assign q_fin = dbz_p[NS-1] ? '1 : cneg_q(dq_p[NS-1], negq_p[NS-1]);
  assign r_fin = cneg_r(rem_p[NS-1], negr_p[NS-1]);

  // Output register: cleared by reset, loads on its handshake, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_dbz       <= 1'b0;
      out_ovf       <= 1'b0;
      out_user      <= '0;
      out_last      <= 1'b0;
    end else begin
      if (res_rdy) out_valid <= vld_p[NS-1];
      if (res_rdy && vld_p[NS-1]) begin
        out_quotient  <= q_fin;
        out_remainder <= r_fin;
        out_dbz       <= dbz_p[NS-1];
        out_ovf       <= ovf_p[NS-1];
        out_user      <= user_p[NS-1];
        out_last      <= last_p[NS-1];
      end
    end
  end

endmodule

// File: tb/tb_str_div_pipe.sv
// Bench for str_div_pipe: three instances (8-bit unsigned BPS=1, 8-bit signed
// BPS=3, 16/12-bit unsigned BPS=3 with a 4-bit sideband) driven with directed
// vectors, a mid-stream reset and a randomized backpressure stream.
module tb_str_div_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // u8: 8/8 unsigned, BPS=1 (latency 9)
  logic [7:0] u8_dvd = '0, u8_dsr = '0, u8_q, u8_r;
  logic [0:0] u8_ui = '0, u8_uo;
  logic u8_li = 1'b0, u8_lo, u8_iv = 1'b0, u8_rdy, u8_dbz, u8_ovf, u8_ov, u8_or = 1'b1;

  // s8: 8/8 signed, BPS=3 (latency 4)
  logic [7:0] s8_dvd = '0, s8_dsr = '0, s8_q, s8_r;
  logic [0:0] s8_ui = '0, s8_uo;
  logic s8_li = 1'b0, s8_lo, s8_iv = 1'b0, s8_rdy, s8_dbz, s8_ovf, s8_ov, s8_or = 1'b1;

  // bp: 16/12 unsigned, BPS=3, UW=4
  logic [15:0] bp_dvd = '0, bp_q;
  logic [11:0] bp_dsr = '0, bp_r;
  logic [3:0]  bp_ui = '0, bp_uo;
  logic bp_li = 1'b0, bp_lo, bp_iv = 1'b0, bp_rdy, bp_dbz, bp_ovf, bp_ov, bp_or = 1'b0;

  str_div_pipe #(.DDW(8), .DSW(8), .BPS(1), .SIGNED(0), .UW(1)) u_u8 (
    .clk(clk), .rst_n(rst_n), .in_dividend(u8_dvd), .in_divisor(u8_dsr),
    .in_user(u8_ui), .in_last(u8_li), .in_valid(u8_iv), .in_ready(u8_rdy),
    .out_quotient(u8_q), .out_remainder(u8_r), .out_dbz(u8_dbz), .out_ovf(u8_ovf),
    .out_user(u8_uo), .out_last(u8_lo), .out_valid(u8_ov), .out_ready(u8_or));

  str_div_pipe #(.DDW(8), .DSW(8), .BPS(3), .SIGNED(1), .UW(1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_dividend(s8_dvd), .in_divisor(s8_dsr),
    .in_user(s8_ui), .in_last(s8_li), .in_valid(s8_iv), .in_ready(s8_rdy),
    .out_quotient(s8_q), .out_remainder(s8_r), .out_dbz(s8_dbz), .out_ovf(s8_ovf),
    .out_user(s8_uo), .out_last(s8_lo), .out_valid(s8_ov), .out_ready(s8_or));

  str_div_pipe #(.DDW(16), .DSW(12), .BPS(3), .SIGNED(0), .UW(4)) u_bp (
    .clk(clk), .rst_n(rst_n), .in_dividend(bp_dvd), .in_divisor(bp_dsr),
    .in_user(bp_ui), .in_last(bp_li), .in_valid(bp_iv), .in_ready(bp_rdy),
    .out_quotient(bp_q), .out_remainder(bp_r), .out_dbz(bp_dbz), .out_ovf(bp_ovf),
    .out_user(bp_uo), .out_last(bp_lo), .out_valid(bp_ov), .out_ready(bp_or));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One transfer through u8; lat = cycle index of out_valid relative to the handshake cycle.
  task automatic u8_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic dbz, output logic ovf, output int lat);
    int n;
    @(negedge clk);
    u8_dvd = a; u8_dsr = b; u8_iv = 1'b1; u8_or = 1'b1;
    #1 chk("u8_in_ready", u8_rdy, 1);
    @(negedge clk);
    u8_iv = 1'b0;
    n = 1;
    while (!u8_ov && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = n; q = u8_q; r = u8_r; dbz = u8_dbz; ovf = u8_ovf;
  endtask

  task automatic s8_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic dbz, output logic ovf, output int lat);
    int n;
    @(negedge clk);
    s8_dvd = a; s8_dsr = b; s8_iv = 1'b1; s8_or = 1'b1;
    #1 chk("s8_in_ready", s8_rdy, 1);
    @(negedge clk);
    s8_iv = 1'b0;
    n = 1;
    while (!s8_ov && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = n; q = s8_q; r = s8_r; dbz = s8_dbz; ovf = s8_ovf;
  endtask

  // Directed vectors: {dividend, divisor, quotient, remainder, dbz, ovf}
  logic [7:0] ua [5] = '{8'd200, 8'd93, 8'hFF, 8'd5, 8'hFF};
  logic [7:0] ub [5] = '{8'd7,   8'd0,  8'd1,  8'd9, 8'h10};
  logic [7:0] uq [5] = '{8'd28,  8'hFF, 8'hFF, 8'd0, 8'h0F};
  logic [7:0] ur [5] = '{8'd4,   8'd93, 8'd0,  8'd5, 8'h0F};
  logic       uz [5] = '{1'b0,   1'b1,  1'b0,  1'b0, 1'b0};

  logic [7:0] sa [6] = '{8'hF9, 8'h07, 8'h80, 8'h9C, 8'h7F, 8'h80};
  logic [7:0] sb [6] = '{8'h02, 8'hFE, 8'hFF, 8'h07, 8'h80, 8'h00};
  logic [7:0] sq [6] = '{8'hFD, 8'hFD, 8'h80, 8'hF2, 8'h00, 8'hFF};
  logic [7:0] sr [6] = '{8'hFF, 8'h01, 8'h00, 8'hFE, 8'h7F, 8'h80};
  logic       sz [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
  logic       so [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] q, r;
    logic dbz, ovf;
    int lat, n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_u8_valid", u8_ov, 0);
    chk("rst_u8_q", u8_q, 0);
    chk("rst_u8_r", u8_r, 0);
    chk("rst_s8_ovf_dbz", {s8_ovf, s8_dbz}, 0);
    chk("rst_bp_user_last", {bp_uo, bp_lo, bp_ov}, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {u8_rdy, s8_rdy, bp_rdy}, 3'b111);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (u8_ov || s8_ov || bp_ov) n++;
    end
    chk("idle_no_valid", n, 0);

    // Unsigned directed
    for (int i = 0; i < 5; i++) begin
      u8_op(ua[i], ub[i], q, r, dbz, ovf, lat);
      chk($sformatf("u8_q_%0d", i), q, uq[i]);
      chk($sformatf("u8_r_%0d", i), r, ur[i]);
      chk($sformatf("u8_dbz_%0d", i), dbz, uz[i]);
      chk($sformatf("u8_ovf_%0d", i), ovf, 0);
      chk($sformatf("u8_lat_%0d", i), lat, 9);
    end

    // Signed directed
    for (int i = 0; i < 6; i++) begin
      s8_op(sa[i], sb[i], q, r, dbz, ovf, lat);
      chk($sformatf("s8_q_%0d", i), q, sq[i]);
      chk($sformatf("s8_r_%0d", i), r, sr[i]);
      chk($sformatf("s8_dbz_%0d", i), dbz, sz[i]);
      chk($sformatf("s8_ovf_%0d", i), ovf, so[i]);
      chk($sformatf("s8_lat_%0d", i), lat, 4);
    end

    // Mid-stream reset with 5 transfers in flight on u8
    @(negedge clk);
    u8_or = 1'b1;
    for (int i = 0; i < 5; i++) begin
      u8_dvd = 8'(i * 10 + 1); u8_dsr = 8'd3; u8_iv = 1'b1;
      @(negedge clk);
    end
    u8_iv = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midrst_valid_drop", u8_ov, 0);
    @(negedge clk);
    chk("midrst_q_zero", u8_q, 0);
    rst_n = 1'b1;
    #1 chk("midrst_in_ready", u8_rdy, 1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (u8_ov) n++;
    end
    chk("midrst_no_stale", n, 0);
    u8_op(8'd100, 8'd10, q, r, dbz, ovf, lat);
    chk("post_rst_q", q, 8'd10);
    chk("post_rst_r", r, 8'd0);
    chk("post_rst_lat", lat, 9);

    // Randomized backpressure stream on bp
    begin
      logic [34:0] exp_q[$];
      logic [34:0] e, g;
      logic [15:0] eq;
      logic [11:0] er;
      int sent, got, cyc, miss;
      logic burst;
      sent = 0; got = 0; cyc = 0; miss = 0;
      while ((sent < 1000 || exp_q.size() > 0) && cyc < 40000) begin
        @(negedge clk);
        burst = (cyc % 200) < 60;
        if (sent < 1000 && (burst || $urandom_range(0, 1) == 1)) begin
          bp_iv  = 1'b1;
          bp_dvd = 16'($urandom);
          bp_dsr = ($urandom_range(0, 15) == 0) ? 12'd0 : 12'($urandom);
          bp_ui  = 4'($urandom);
          bp_li  = 1'($urandom);
        end else begin
          bp_iv = 1'b0;
        end
        bp_or = burst ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        if (burst && (cyc % 200) >= 20 && sent < 1000 && !bp_ov) miss++;
        if (bp_iv && bp_rdy) begin
          if (bp_dsr == 12'd0) begin
            eq = 16'hFFFF;
            er = bp_dvd[11:0];
          end else begin
            eq = bp_dvd / {4'b0, bp_dsr};
            er = 12'(bp_dvd % {4'b0, bp_dsr});
          end
          exp_q.push_back({eq, er, (bp_dsr == 12'd0), 1'b0, bp_ui, bp_li});
          sent++;
        end
        if (bp_ov && bp_or) begin
          g = {bp_q, bp_r, bp_dbz, bp_ovf, bp_uo, bp_lo};
          if (exp_q.size() == 0) begin
            chk("bp_extra", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("bp_xfer", 64'(g), 64'(e));
          end
          got++;
        end
        cyc++;
      end
      chk("bp_count", got, 1000);
      chk("bp_rate_miss", miss, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/str_div_pipe.md
STR_DIV_PIPE -- requirements
Module: str_div_pipe

Interface
REQ-001 Parameter DDW, default 16: dividend and quotient width in bits, at least 2.
REQ-002 Parameter DSW, default 16: divisor and remainder width in bits, from 2 to DDW inclusive.
REQ-003 Parameter BPS, default 1: quotient bits resolved per registered stage, from 1 to DDW.
REQ-004 Parameter SIGNED, default 0: 0 selects unsigned operands, 1 selects two's-complement operands.
REQ-005 Parameter UW, default 1: width of the user sideband carried alongside each transfer, at least 1.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_dividend  input  DDW  dividend.
REQ-009 in_divisor  input  DSW  divisor.
REQ-010 in_user  input  UW  sideband, passed through unchanged.
REQ-011 in_last  input  1  end-of-packet marker, passed through unchanged.
REQ-012 in_valid  input  1  input transfer valid.
REQ-013 in_ready  output  1  input transfer accepted when high together with in_valid.
REQ-014 out_quotient  output  DDW  quotient.
REQ-015 out_remainder  output  DSW  remainder.
REQ-016 out_dbz  output  1  divisor was zero.
REQ-017 out_ovf  output  1  signed overflow (most-negative divided by -1).
REQ-018 out_user  output  UW  delayed in_user.
REQ-019 out_last  output  1  delayed in_last.
REQ-020 out_valid  output  1  output transfer valid.
REQ-021 out_ready  input  1  downstream ready.

Function
REQ-022 The pipeline SHALL have NS = ceil(DDW/BPS) iteration stages followed by one registered result stage, so latency is NS+1 cycles from input handshake to out_valid with no stalls.
REQ-023 Every stage SHALL use the skid-free rule: stage ready = ~stage_valid | downstream_ready; stage_valid is set on upstream handshake and cleared when downstream accepts without a new upstream handshake.
REQ-024 Throughput SHALL be one result per cycle while out_ready is held high; any out_ready pattern SHALL lose, duplicate or reorder no transfer.
REQ-025 Stage registers SHALL load only on their own input handshake and SHALL hold while stalled.
REQ-026 Each iteration stage SHALL perform BPS restoring steps: shift the partial remainder left by one and bring in the next dividend MSB, compare against |divisor|, subtract if greater or equal, and shift the compare result into the quotient LSB.
REQ-027 When DDW is not a multiple of BPS, the last iteration stage SHALL perform only the remaining DDW mod BPS steps.
REQ-028 The partial remainder SHALL be DSW+1 bits wide internally so that no compare overflows.
REQ-029 If SIGNED=1, the operand magnitudes SHALL be formed combinationally at the input; the dividend magnitude SHALL be held as unsigned DDW bits, so |-2^(DDW-1)| is exact.
REQ-030 Sign flags, dbz, ovf, user and last SHALL travel through every stage together with their data.
REQ-031 If SIGNED=1, the result stage SHALL negate the quotient when the operand signs differ and SHALL negate the remainder when the dividend is negative (truncation toward zero).
REQ-032 Divisor zero SHALL produce out_dbz=1, out_quotient all ones, out_remainder = dividend truncated to DSW bits, and out_ovf=0.
REQ-033 Signed overflow (SIGNED=1, dividend -2^(DDW-1), divisor -1) SHALL produce out_ovf=1, out_quotient = -2^(DDW-1), and out_remainder=0.
REQ-034 If SIGNED=0, out_ovf SHALL be constant 0.
REQ-035 The identity dividend = quotient*divisor + remainder SHALL hold for every non-dbz, non-ovf result.

Reset
REQ-036 While rst_n is low, all valid flags and out_valid SHALL be 0, and out_quotient, out_remainder, out_dbz, out_ovf, out_user and out_last SHALL be 0.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight transfers immediately.
REQ-038 After rst_n deasserts, in_ready SHALL be 1.
REQ-039 No output SHALL go valid until a new input handshake has occurred after reset release.

Verification
REQ-040 Basic unsigned: DDW=DSW=8, SIGNED=0, BPS=1, 200/7 with out_ready=1 -> quotient 28, remainder 4, out_valid exactly 9 cycles after the handshake.
REQ-041 Signed: SIGNED=1, 8-bit, inputs -7/2, 7/-2 and -128/-1 -> (-3,-1), then (-3,1), then (-128,0) with ovf=1.
REQ-042 Divide by zero: 8-bit unsigned 93/0 -> quotient 255, remainder 93, dbz=1.
REQ-043 Backpressure: 1000 random transfers, random in_valid and random out_ready, DDW=16, DSW=12, BPS=3 -> all results match the reference model, in order, with user and last intact, and one result per cycle during the full-throughput bursts.
REQ-044 Reset mid-stream: rst_n pulsed low with 5 transfers in flight -> out_valid drops within the reset, and no stale result appears afterwards.
